// File: rtl/regfile_pkg.sv
// Shared register-file constants and helpers for the register-file write path.
package regfile_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned NUM_REGS  = 32;

    typedef enum logic {
        Src0 = 1'b0,
        Src1 = 1'b1
    } src_e;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_IDX_W-1:0] rw);
        logic [NUM_REGS-1:0] oh;
        oh     = '0;
        oh[rw] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/regwr_fifo.sv
// Per-requester write queue holding {rw, w}; exposes every entry's valid bit and
// register index so the owner can build the outstanding-register mask.
module regwr_fifo
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                push,
    input  logic                                pop,
    input  logic [REG_IDX_W-1:0]                push_rw,
    input  logic [DATA_W-1:0]                   push_w,
    output logic                                full,
    output logic                                empty,
    output logic [REG_IDX_W-1:0]                head_rw,
    output logic [DATA_W-1:0]                   head_w,
    output logic [DEPTH-1:0]                    ent_valid,
    output logic [DEPTH-1:0][REG_IDX_W-1:0]     ent_rw
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0]                  wr_ptr_q;
    logic [AW-1:0]                  rd_ptr_q;
    logic [DEPTH-1:0]               valid_q;
    logic [DEPTH-1:0][REG_IDX_W-1:0] rw_q;
    logic [DATA_W-1:0]              w_q [DEPTH];

    // On a simultaneous push/pop of a full queue both pointers hit the same slot;
    // the push is written last so the slot stays valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            valid_q  <= '0;
            rw_q     <= '0;
        end else begin
            if (pop) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= rd_ptr_q + AW'(1);
            end
            if (push) begin
                valid_q[wr_ptr_q] <= 1'b1;
                rw_q[wr_ptr_q]    <= push_rw;
                wr_ptr_q          <= wr_ptr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            w_q[wr_ptr_q] <= push_w;
        end
    end

    assign full      = &valid_q;
    assign empty     = ~|valid_q;
    assign head_rw   = rw_q[rd_ptr_q];
    assign head_w    = w_q[rd_ptr_q];
    assign ent_valid = valid_q;
    assign ent_rw    = rw_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write arbiter with per-requester queues and hazard tracking.
// Define REGWR_ARB_RR_EN for round-robin arbitration; default is fixed priority to requester 0.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    input  logic [REG_IDX_W-1:0] req0_rw,
    input  logic [DATA_W-1:0]    req0_w,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [REG_IDX_W-1:0] req1_rw,
    input  logic [DATA_W-1:0]    req1_w,
    output logic                 req1_ready,
    output logic                 wr_we,
    output logic [REG_IDX_W-1:0] wr_rw,
    output logic [DATA_W-1:0]    wr_w,
    output logic [NUM_REGS-1:0]  busy
);

    logic                                 push0, push1, pop0, pop1;
    logic                                 full0, full1, empty0, empty1;
    logic [REG_IDX_W-1:0]                 head_rw0, head_rw1;
    logic [DATA_W-1:0]                    head_w0, head_w1;
    logic [FIFO_DEPTH-1:0]                ent_valid0, ent_valid1;
    logic [FIFO_DEPTH-1:0][REG_IDX_W-1:0] ent_rw0, ent_rw1;
    logic [NUM_REGS-1:0]                  held0, held1;
    logic                                 contended;
    logic                                 rdy0, rdy1;
    src_e                                 wr_src;
`ifdef REGWR_ARB_RR_EN
    src_e                                 rr_ptr;
`endif

    regwr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push0),
        .pop       (pop0),
        .push_rw   (req0_rw),
        .push_w    (req0_w),
        .full      (full0),
        .empty     (empty0),
        .head_rw   (head_rw0),
        .head_w    (head_w0),
        .ent_valid (ent_valid0),
        .ent_rw    (ent_rw0)
    );

    regwr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push1),
        .pop       (pop1),
        .push_rw   (req1_rw),
        .push_w    (req1_w),
        .full      (full1),
        .empty     (empty1),
        .head_rw   (head_rw1),
        .head_w    (head_w1),
        .ent_valid (ent_valid1),
        .ent_rw    (ent_rw1)
    );

    // Registers held per requester: queued entries plus the output stage it owns.
    always_comb begin
        held0 = '0;
        held1 = '0;
        for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            if (ent_valid0[i]) held0 |= reg_onehot(ent_rw0[i]);
            if (ent_valid1[i]) held1 |= reg_onehot(ent_rw1[i]);
        end
        if (wr_we) begin
            if (wr_src == Src0) held0 |= reg_onehot(wr_rw);
            else                held1 |= reg_onehot(wr_rw);
        end
    end

    assign busy = held0 | held1;

    assign contended = !empty0 && !empty1;

    always_comb begin
        pop0 = 1'b0;
        pop1 = 1'b0;
        if (contended) begin
`ifdef REGWR_ARB_RR_EN
            pop0 = (rr_ptr == Src0);
            pop1 = (rr_ptr == Src1);
`else
            pop0 = 1'b1;
`endif
        end else begin
            pop0 = !empty0;
            pop1 = !empty1;
        end
    end

    // rw==0 offers are swallowed, so they never need queue space.
    assign rdy0 = (req0_rw == '0) || ((!full0 || pop0) && !held1[req0_rw]);
    assign rdy1 = (req1_rw == '0) ||
                  ((!full1 || pop1) && !held0[req1_rw] &&
                   !(req0_valid && rdy0 && (req0_rw == req1_rw)));

    assign req0_ready = rst_n && rdy0;
    assign req1_ready = rst_n && rdy1;

    assign push0 = req0_valid && req0_ready && (req0_rw != '0);
    assign push1 = req1_valid && req1_ready && (req1_rw != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_we  <= 1'b0;
            wr_rw  <= '0;
            wr_w   <= '0;
            wr_src <= Src0;
`ifdef REGWR_ARB_RR_EN
            rr_ptr <= Src0;
`endif
        end else begin
            wr_we <= pop0 || pop1;
            if (pop0) begin
                wr_rw  <= head_rw0;
                wr_w   <= head_w0;
                wr_src <= Src0;
            end else if (pop1) begin
                wr_rw  <= head_rw1;
                wr_w   <= head_w1;
                wr_src <= Src1;
            end
`ifdef REGWR_ARB_RR_EN
            if (contended) begin
                rr_ptr <= (rr_ptr == Src0) ? Src1 : Src0;
            end
`endif
        end
    end

endmodule
